if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage_if.sv | 26 ++
 rtl/if_stage.sv | 101 ++++++++++
 tb/tb_if_stage.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and the memory (slave).
// Handshake: imem_req is a one-cycle strobe qualifying imem_addr. The memory later
// returns exactly one imem_rvalid pulse with imem_rdata, at least one cycle after
// the request. At most one request is outstanding, so no ready signal is needed.
interface if_stage_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic            imem_rvalid;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_rvalid
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_rvalid
  );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: one outstanding imem request, a one-word instruction
// buffer, ID-stage redirects and HDU stalls.
module if_stage #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_write,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  if_stage_if.master      imem,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc4_out,
  output logic [31:0]     instr_out,
  output logic            instr_valid,
  output logic [1:0]      dbg_state_o
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } state_e;

  localparam logic [XLEN-1:0] FOUR     = XLEN'(4);
  localparam logic [XLEN-1:0] PC_RESET = {RESET_PC[XLEN-1:2], 2'b00};

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc4_q;
  logic [31:0]     ibuf_q, ibuf_d;
  logic            req;
  logic [XLEN-1:0] redir_pc;

  assign redir_pc = {redirect_pc[XLEN-1:2], 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_REQ;
      pc_q    <= PC_RESET;
      pc4_q   <= PC_RESET + FOUR;
      ibuf_q  <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pc4_q   <= pc_d + FOUR;
      ibuf_q  <= ibuf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ibuf_d  = ibuf_q;
    req     = 1'b0;
    unique case (state_q)
      S_REQ: begin
        req = !redirect;
        if (redirect) pc_d = redir_pc;
        else          state_d = S_WAIT;
      end
      S_WAIT: begin
        if (redirect) begin
          pc_d    = redir_pc;
          state_d = imem.imem_rvalid ? S_REQ : S_DROP;
        end else if (imem.imem_rvalid) begin
          ibuf_d  = imem.imem_rdata;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        // Redirect wins over pc_write: the sequential successor is not fetched.
        if (redirect) begin
          pc_d    = redir_pc;
          state_d = S_REQ;
        end else if (pc_write) begin
          req     = 1'b1;
          pc_d    = pc4_q;
          state_d = S_WAIT;
        end
      end
      S_DROP: begin
        if (redirect) pc_d = redir_pc;
        if (imem.imem_rvalid) state_d = S_REQ;
      end
    endcase
  end

  // In S_HOLD the only request that can go out is the sequential one at pc+4.
  assign imem.imem_req  = req & !rst;
  assign imem.imem_addr = (state_q == S_HOLD) ? pc4_q : pc_q;

  assign pc_out      = pc_q;
  assign pc4_out     = pc4_q;
  assign instr_valid = (state_q == S_HOLD);
  assign instr_out   = instr_valid ? ibuf_q : 32'h0000_0000;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: transaction-level fetch model, per-cycle compare,
// and literal checkpoints for the documented scenarios.
module tb_if_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        pc_write = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] pc_out, pc4_out, instr_out;
  logic        instr_valid;
  logic [1:0]  dbg_state;

  if_stage_if #(.XLEN(32)) bus ();

  if_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_write    (pc_write),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem        (bus.master),
    .pc_out      (pc_out),
    .pc4_out     (pc4_out),
    .instr_out   (instr_out),
    .instr_valid (instr_valid),
    .dbg_state_o (dbg_state)
  );

  // ---------------- memory: auto 1-cycle responder or manual drive ----------------
  logic        mem_auto = 1'b1;
  logic        auto_rv = 1'b0;
  logic [31:0] auto_rd = 32'h0;
  logic        man_rv = 1'b0;
  logic [31:0] man_rd = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0) ? 32'h2001_0005 : (a ^ 32'h5A00_0013);
  endfunction

  assign bus.imem_rvalid = mem_auto ? auto_rv : man_rv;
  assign bus.imem_rdata  = mem_auto ? auto_rd : man_rd;

  always @(posedge clk) begin
    logic        fire;
    logic [31:0] a;
    fire = mem_auto && !rst && bus.imem_req;
    a    = bus.imem_addr;
    #1;
    auto_rv = fire;
    auto_rd = fire ? mem_word(a) : 32'h0;
  end

  // ---------------- scoreboard / counters ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h (state %0d)", name, $time, act, exp, dbg_state);
    end
  endtask

  // ---------------- behavioural model (transaction level) ----------------
  logic [31:0] m_pc = RST_PC;
  logic [31:0] m_buf = 32'h0;
  logic        m_have = 1'b0;   // a fetched word is held for ID
  logic        m_pend = 1'b0;   // a request is outstanding
  logic        m_stale = 1'b0;  // the outstanding response must be thrown away
  logic        model_ok = 1'b0;
  logic        saw_deadbeef = 1'b0;

  function automatic logic [31:0] align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_pc = RST_PC; m_buf = 32'h0; m_have = 1'b0; m_pend = 1'b0; m_stale = 1'b0;
      model_ok = 1'b1;
    end else if (m_pend) begin
      if (bus.imem_rvalid) begin
        if (!m_stale && !redirect) begin
          m_have = 1'b1;
          m_buf  = bus.imem_rdata;
        end
        m_pend  = 1'b0;
        m_stale = 1'b0;
      end else if (redirect) begin
        m_stale = 1'b1;
      end
      if (redirect) m_pc = align(redirect_pc);
    end else if (m_have) begin
      if (redirect) begin
        m_pc = align(redirect_pc); m_have = 1'b0;
      end else if (pc_write) begin
        m_pc = m_pc + 32'd4; m_have = 1'b0; m_pend = 1'b1;
      end
    end else begin
      if (redirect) m_pc = align(redirect_pc);
      else          m_pend = 1'b1;
    end
  end

  // One compare process: every cycle once the model has seen reset.
  always @(negedge clk) begin
    logic        e_req;
    logic [31:0] e_addr;
    if (model_ok) begin
      e_req  = !rst && !m_pend && (m_have ? (pc_write && !redirect) : !redirect);
      e_addr = m_have ? m_pc + 32'd4 : m_pc;
      chk("imem_req", {31'b0, bus.imem_req}, {31'b0, e_req});
      if (e_req) chk("imem_addr", bus.imem_addr, e_addr);
      chk("pc_out", pc_out, m_pc);
      chk("pc4_out", pc4_out, m_pc + 32'd4);
      chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_have});
      chk("instr_out", instr_out, m_have ? m_buf : 32'h0);
      if (instr_valid && instr_out == 32'hDEAD_BEEF) saw_deadbeef = 1'b1;
    end
  end

  // ---------------- driver ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cnt;
    fork
      begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
      end
    join_none

    // Reset
    rst = 1'b1;
    cyc(); cyc();
    @(negedge clk);
    chk("lit_rst_req", {31'b0, bus.imem_req}, 32'h0);
    chk("lit_rst_pc", pc_out, 32'h0);
    chk("lit_rst_valid", {31'b0, instr_valid}, 32'h0);
    chk("lit_rst_instr", instr_out, 32'h0);

    // First fetch: request in cycle 1, held word in cycle 3
    cyc(); rst = 1'b0;
    @(negedge clk);
    chk("lit_c1_req", {31'b0, bus.imem_req}, 32'h1);
    chk("lit_c1_addr", bus.imem_addr, 32'h0);
    cyc(); cyc();
    @(negedge clk);
    chk("lit_c3_valid", {31'b0, instr_valid}, 32'h1);
    chk("lit_c3_instr", instr_out, 32'h2001_0005);
    chk("lit_c3_pc4", pc4_out, 32'h4);

    // Stall for 5 cycles, then advance
    for (int i = 0; i < 5; i++) begin
      cyc();
      @(negedge clk);
      chk("lit_stall_instr", instr_out, 32'h2001_0005);
      chk("lit_stall_req", {31'b0, bus.imem_req}, 32'h0);
    end
    cyc(); pc_write = 1'b1;
    @(negedge clk);
    chk("lit_adv_req", {31'b0, bus.imem_req}, 32'h1);
    chk("lit_adv_addr", bus.imem_addr, 32'h4);
    cyc(); pc_write = 1'b0;
    cyc();

    // Redirect while waiting, late response must be dropped
    mem_auto = 1'b0;
    pc_write = 1'b1;
    cyc(); pc_write = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h0000_0040;
    cyc(); redirect = 1'b0;
    cyc();
    man_rv = 1'b1; man_rd = 32'hDEAD_BEEF;
    cyc(); man_rv = 1'b0; mem_auto = 1'b1;
    @(negedge clk);
    chk("lit_redir_req", {31'b0, bus.imem_req}, 32'h1);
    chk("lit_redir_addr", bus.imem_addr, 32'h40);
    cyc(); cyc();
    chk("lit_no_deadbeef", {31'b0, saw_deadbeef}, 32'h0);

    // Redirect beats pc_write in hold
    redirect = 1'b1; redirect_pc = 32'h10;
    cyc(); redirect = 1'b0;
    cyc(); cyc();
    redirect = 1'b1; pc_write = 1'b1; redirect_pc = 32'h100;
    @(negedge clk);
    chk("lit_prio_pc", pc_out, 32'h10);
    chk("lit_prio_noreq", {31'b0, bus.imem_req}, 32'h0);
    cyc(); redirect = 1'b0; pc_write = 1'b0;
    @(negedge clk);
    chk("lit_prio_newpc", pc_out, 32'h100);
    cyc(); cyc();

    // Alignment and wrap-around
    redirect = 1'b1; redirect_pc = 32'h0000_0023;
    cyc(); redirect = 1'b0;
    @(negedge clk);
    chk("lit_align_addr", bus.imem_addr, 32'h20);
    cyc(); cyc();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    cyc(); redirect = 1'b0;
    @(negedge clk);
    chk("lit_wrap_pc4", pc4_out, 32'h0);
    cyc(); cyc();
    pc_write = 1'b1;
    @(negedge clk);
    chk("lit_wrap_addr", bus.imem_addr, 32'h0);
    cyc(); pc_write = 1'b0;
    @(negedge clk);
    chk("lit_wrap_pc", pc_out, 32'h0);
    chk("lit_wrap_pc4b", pc4_out, 32'h4);
    cyc();

    // Throughput: one instruction every two cycles
    pc_write = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (instr_valid) cnt++;
      cyc();
    end
    pc_write = 1'b0;
    chk("lit_throughput", cnt, 32'd10);
    cyc();

    // Manual memory corner cases: redirect+rvalid in wait, redirects in drop
    mem_auto = 1'b0;
    pc_write = 1'b1;
    cyc(); pc_write = 1'b0;
    man_rv = 1'b1; man_rd = 32'hBAD0_0001; redirect = 1'b1; redirect_pc = 32'h80;
    cyc(); man_rv = 1'b0; redirect = 1'b0;
    @(negedge clk);
    chk("lit_wr_addr", bus.imem_addr, 32'h80);
    cyc();
    redirect = 1'b1; redirect_pc = 32'h90;
    cyc(); redirect_pc = 32'hA0;
    cyc(); redirect = 1'b0;
    @(negedge clk);
    chk("lit_drop_pc", pc_out, 32'hA0);
    redirect = 1'b1; redirect_pc = 32'hB0; man_rv = 1'b1; man_rd = 32'hBAD0_0002;
    cyc(); redirect = 1'b0; man_rv = 1'b0;
    @(negedge clk);
    chk("lit_drop_addr", bus.imem_addr, 32'hB0);
    cyc();
    man_rv = 1'b1; man_rd = 32'h1234_5678;
    cyc(); man_rv = 1'b0;
    @(negedge clk);
    chk("lit_manual_instr", instr_out, 32'h1234_5678);
    man_rv = 1'b1; man_rd = 32'hBAD0_0003;
    cyc(); man_rv = 1'b0;
    @(negedge clk);
    chk("lit_hold_ignore", instr_out, 32'h1234_5678);

    // Reset while a request is outstanding, stray response afterwards
    pc_write = 1'b1;
    cyc(); pc_write = 1'b0;
    rst = 1'b1;
    cyc(); rst = 1'b0;
    man_rv = 1'b1; man_rd = 32'hBAD0_0004;
    @(negedge clk);
    chk("lit_rrst_addr", bus.imem_addr, RST_PC);
    cyc(); man_rv = 1'b0;
    cyc();
    man_rv = 1'b1; man_rd = 32'hCAFE_0001;
    cyc(); man_rv = 1'b0;
    @(negedge clk);
    chk("lit_rrst_instr", instr_out, 32'hCAFE_0001);
    chk("lit_rrst_pc", pc_out, RST_PC);
    cyc(); cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
